// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared constants for the decode-stage hazard scoreboard:
//               default sizes, EXEC result-source encodings and the
//               PREG index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

  localparam int PREG_COUNT_DEFAULT = 64;
  localparam int PERF_WIDTH_DEFAULT = 32;

  // EXEC result source; only the ALU result can be bypassed from EXEC.
  localparam logic [1:0] EX_ALU = 2'd0;
  localparam logic [1:0] EX_MEM = 2'd1;
  localparam logic [1:0] EX_MUL = 2'd2;
  localparam logic [1:0] EX_DIV = 2'd3;

  // Width of a physical-register index.
  function automatic int preg_bus(input int n);
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : Decode / pipeline-stage signal bundle seen by the hazard
//               scoreboard. master = pipeline side, slave = scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int PREG_COUNT = PREG_COUNT_DEFAULT,
  parameter int PERF_WIDTH = PERF_WIDTH_DEFAULT
);
  localparam int PREG_BUS = preg_bus(PREG_COUNT);

  logic                  dec_valid;
  logic                  dec_rs_enable;
  logic [PREG_BUS-1:0]   dec_prs_addr;
  logic                  dec_rt_enable;
  logic [PREG_BUS-1:0]   dec_prt_addr;
  logic                  dec_wb_reg;
  logic [PREG_BUS-1:0]   dec_write_addr;
  logic                  exec_wb_reg;
  logic [1:0]            exec_exec_src;
  logic [PREG_BUS-1:0]   exec_write_addr;
  logic                  mem_wb_reg;
  logic [PREG_BUS-1:0]   mem_write_addr;
  logic                  wb_wb_reg;
  logic [PREG_BUS-1:0]   wb_write_addr;
  logic                  flush_exec;
  logic                  stall_dec;
  logic [PREG_BUS:0]     pending_count;
  logic [PERF_WIDTH-1:0] stall_cycles;

  modport master (
    output dec_valid, dec_rs_enable, dec_prs_addr, dec_rt_enable, dec_prt_addr,
           dec_wb_reg, dec_write_addr, exec_wb_reg, exec_exec_src, exec_write_addr,
           mem_wb_reg, mem_write_addr, wb_wb_reg, wb_write_addr, flush_exec,
    input  stall_dec, pending_count, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_rs_enable, dec_prs_addr, dec_rt_enable, dec_prt_addr,
           dec_wb_reg, dec_write_addr, exec_wb_reg, exec_exec_src, exec_write_addr,
           mem_wb_reg, mem_write_addr, wb_wb_reg, wb_write_addr, flush_exec,
    output stall_dec, pending_count, stall_cycles
  );

endinterface
`default_nettype wire

// File: rtl/hazard_pending_table.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pending_table
// Description : Per-PREG pending-write vector with set-over-clear priority
//               and a registered popcount of the table.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_pending_table
  import hazard_scoreboard_pkg::*;
#(
  parameter  int PREG_COUNT = PREG_COUNT_DEFAULT,
  localparam int AW         = preg_bus(PREG_COUNT)
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  set_en_i,
  input  wire logic [AW-1:0]         set_addr_i,
  input  wire logic                  flush_clr_en_i,
  input  wire logic [AW-1:0]         flush_clr_addr_i,
  input  wire logic                  wb_clr_en_i,
  input  wire logic [AW-1:0]         wb_clr_addr_i,
  output logic      [PREG_COUNT-1:0] pending_o,
  output logic      [AW:0]           count_o
);

  logic [PREG_COUNT-1:0] pending_q, pending_d;
  logic [AW:0]           count_q, count_d;

  // Next table: clears first, then the issue set so a reallocated PREG
  // reflects its new owner; PREG 0 is forced clear.
  always_comb begin
    pending_d = pending_q;
    if (wb_clr_en_i)    pending_d[wb_clr_addr_i]    = 1'b0;
    if (flush_clr_en_i) pending_d[flush_clr_addr_i] = 1'b0;
    if (set_en_i)       pending_d[set_addr_i]       = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Popcount of the next table so the registered count tracks the register.
  always_comb begin
    count_d = '0;
    for (int i = 1; i < PREG_COUNT; i++) begin
      count_d = count_d + {{AW{1'b0}}, pending_d[i]};
    end
  end

  // Table and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending_o = pending_q;
  assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Decode-stage hazard check against in-flight PREG writes.
//               Stalls decode when a source is pending and no bypass path
//               (EXEC ALU, MEM, WB) can supply it, or a load sits in EXEC.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int PREG_COUNT = PREG_COUNT_DEFAULT,
  parameter int PERF_WIDTH = PERF_WIDTH_DEFAULT
) (
  input wire logic          clk,
  input wire logic          rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam int AW = preg_bus(PREG_COUNT);

  logic [PREG_COUNT-1:0] pending_vec;
  logic [AW:0]           pending_cnt;
  logic                  rs_haz, rt_haz, stall, issue;
  logic [PERF_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  // A source hazards when a load in EXEC targets it (youngest producer
  // wins over MEM/WB matches) or it is pending with no bypass available.
  function automatic logic haz_f(
    input logic          pend,
    input logic [AW-1:0] a,
    input logic          ex_w,
    input logic [1:0]    ex_src,
    input logic [AW-1:0] ex_a,
    input logic          mem_w,
    input logic [AW-1:0] mem_a,
    input logic          wb_w,
    input logic [AW-1:0] wb_a
  );
    logic fwd, load;
    fwd  = (ex_w && ex_src == EX_ALU && a == ex_a) ||
           (mem_w && a == mem_a) || (wb_w && a == wb_a);
    load = ex_w && ex_src != EX_ALU && a == ex_a;
    return (a != '0) && (load || (pend && !fwd));
  endfunction

  // Zero-latency stall and issue decision.
  always_comb begin
    rs_haz = haz_f(pending_vec[bus.dec_prs_addr], bus.dec_prs_addr,
                   bus.exec_wb_reg, bus.exec_exec_src, bus.exec_write_addr,
                   bus.mem_wb_reg, bus.mem_write_addr,
                   bus.wb_wb_reg, bus.wb_write_addr);
    rt_haz = haz_f(pending_vec[bus.dec_prt_addr], bus.dec_prt_addr,
                   bus.exec_wb_reg, bus.exec_exec_src, bus.exec_write_addr,
                   bus.mem_wb_reg, bus.mem_write_addr,
                   bus.wb_wb_reg, bus.wb_write_addr);
    stall  = bus.dec_valid && !bus.flush_exec &&
             ((bus.dec_rs_enable && rs_haz) || (bus.dec_rt_enable && rt_haz));
    issue  = bus.dec_valid && !stall && !bus.flush_exec &&
             bus.dec_wb_reg && (bus.dec_write_addr != '0);
  end

  hazard_pending_table #(
    .PREG_COUNT (PREG_COUNT)
  ) u_table (
    .clk              (clk),
    .rst_n            (rst_n),
    .set_en_i         (issue),
    .set_addr_i       (bus.dec_write_addr),
    .flush_clr_en_i   (bus.flush_exec && bus.exec_wb_reg),
    .flush_clr_addr_i (bus.exec_write_addr),
    .wb_clr_en_i      (bus.wb_wb_reg),
    .wb_clr_addr_i    (bus.wb_write_addr),
    .pending_o        (pending_vec),
    .count_o          (pending_cnt)
  );

  // Stall-cycle counter next value; wraps naturally.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign bus.stall_dec     = stall;
  assign bus.pending_count = pending_cnt;
  assign bus.stall_cycles  = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed scoreboard bench for hazard_scoreboard. Stimulus
//               pushes expected stall/count/cycle values; a monitor pops and
//               compares them mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int PREG_COUNT = 64;
  localparam int PERF_WIDTH = 4;

  typedef struct packed {
    logic       stall;
    logic [7:0] cnt;
    logic [3:0] cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t  exp_q[$];
  string name_q[$];
  logic [3:0] exp_sc;
  int checks;
  int errors;

  hazard_scoreboard_if #(.PREG_COUNT(PREG_COUNT), .PERF_WIDTH(PERF_WIDTH)) bus ();

  hazard_scoreboard #(.PREG_COUNT(PREG_COUNT), .PERF_WIDTH(PERF_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.dec_valid = 0; bus.dec_rs_enable = 0; bus.dec_prs_addr = '0;
    bus.dec_rt_enable = 0; bus.dec_prt_addr = '0; bus.dec_wb_reg = 0;
    bus.dec_write_addr = '0; bus.exec_wb_reg = 0; bus.exec_exec_src = EX_ALU;
    bus.exec_write_addr = '0; bus.mem_wb_reg = 0; bus.mem_write_addr = '0;
    bus.wb_wb_reg = 0; bus.wb_write_addr = '0; bus.flush_exec = 0;
  endtask

  task automatic set_dec(input logic rse, input logic [5:0] rs, input logic rte,
                         input logic [5:0] rt, input logic w, input logic [5:0] wa);
    bus.dec_valid = 1; bus.dec_rs_enable = rse; bus.dec_prs_addr = rs;
    bus.dec_rt_enable = rte; bus.dec_prt_addr = rt;
    bus.dec_wb_reg = w; bus.dec_write_addr = wa;
  endtask

  task automatic set_ex(input logic [1:0] src, input logic [5:0] a);
    bus.exec_wb_reg = 1; bus.exec_exec_src = src; bus.exec_write_addr = a;
  endtask

  task automatic set_mem(input logic [5:0] a);
    bus.mem_wb_reg = 1; bus.mem_write_addr = a;
  endtask

  task automatic set_wb(input logic [5:0] a);
    bus.wb_wb_reg = 1; bus.wb_write_addr = a;
  endtask

  // Queue the expectation for the current cycle; the stall counter model
  // advances after every cycle expected to stall.
  task automatic chk(input string nm, input logic s, input int c);
    exp_t e;
    e.stall = s;
    e.cnt   = c[7:0];
    e.cyc   = exp_sc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (s) exp_sc = exp_sc + 4'd1;
  endtask

  // Monitor: compare the DUT mid-cycle against the queued expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (bus.stall_dec !== e.stall) begin
          errors++;
          $display("FAIL %s stall_dec: got %b expected %b", nm, bus.stall_dec, e.stall);
        end
        checks++;
        if ({1'b0, bus.pending_count} !== e.cnt) begin
          errors++;
          $display("FAIL %s pending_count: got %0d expected %0d", nm, bus.pending_count, e.cnt);
        end
        checks++;
        if (bus.stall_cycles !== e.cyc) begin
          errors++;
          $display("FAIL %s stall_cycles: got %0d expected %0d", nm, bus.stall_cycles, e.cyc);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    exp_sc = 4'd0;
    rst_n  = 1'b0;
    idle();

    step(); chk("reset", 0, 0);

    // 1: ALU producer bypassed from EXEC, then cleared at WB
    step(); rst_n = 1'b1; idle(); set_dec(0, 0, 0, 0, 1, 5); chk("t1_issue", 0, 0);
    step(); idle(); set_ex(EX_ALU, 5); set_dec(1, 5, 0, 0, 0, 0); chk("t1_exec_fwd", 0, 1);
    step(); idle(); set_mem(5); chk("t1_mem", 0, 1);
    step(); idle(); set_wb(5); chk("t1_wb", 0, 1);
    step(); idle(); chk("t1_cleared", 0, 0);

    // 2: load-use stalls one cycle, MEM forward releases it
    step(); idle(); set_ex(EX_MEM, 7); set_dec(1, 7, 0, 0, 0, 0); chk("t2_load_use", 1, 0);
    step(); idle(); set_mem(7); set_dec(1, 7, 0, 0, 0, 0); chk("t2_mem_fwd", 0, 0);

    // 3: long-latency producer stalls until its WB
    step(); idle(); set_dec(0, 0, 0, 0, 1, 9); chk("t3_issue_div", 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); idle(); set_dec(0, 0, 1, 9, 0, 0); chk("t3_div_wait", 1, 1);
    end
    step(); idle(); set_wb(9); set_dec(0, 0, 1, 9, 0, 0); chk("t3_wb_fwd", 0, 1);
    step(); idle(); chk("t3_cleared", 0, 0);

    // 4: set beats WB clear; flush clears EXEC dest and blocks issue
    step(); idle(); set_dec(0, 0, 0, 0, 1, 4); chk("t4_issue_p4", 0, 0);
    step(); idle(); set_dec(0, 0, 0, 0, 1, 3); set_wb(3); chk("t4_set_beats_clr", 0, 1);
    step(); idle(); bus.flush_exec = 1; set_ex(EX_ALU, 4); set_dec(1, 3, 0, 0, 1, 10);
    chk("t4_flush", 0, 2);
    step(); idle(); set_dec(1, 3, 0, 0, 0, 0); chk("t4_p3_held", 1, 1);
    step(); idle(); set_wb(3); chk("t4_wb_p3", 0, 1);
    step(); idle(); chk("t4_empty", 0, 0);

    // 5: PREG 0 never hazards and is never set
    step(); idle(); set_ex(EX_MEM, 0); set_dec(1, 0, 1, 0, 1, 0); chk("t5_p0", 0, 0);
    step(); idle(); chk("t5_p0_after", 0, 0);

    // 6: fill, async reset mid-stall, then counter wrap
    step(); idle(); set_dec(0, 0, 0, 0, 1, 1);  chk("t6_fill1", 0, 0);
    step(); idle(); set_dec(0, 0, 0, 0, 1, 2);  chk("t6_fill2", 0, 1);
    step(); idle(); set_dec(0, 0, 0, 0, 1, 11); chk("t6_fill3", 0, 2);
    step(); idle(); set_dec(1, 11, 0, 0, 0, 0); chk("t6_stall_a", 1, 3);
    step(); idle(); set_dec(1, 11, 0, 0, 0, 0); chk("t6_stall_b", 1, 3);
    step(); idle(); set_dec(1, 11, 0, 0, 0, 0); rst_n = 1'b0; exp_sc = 4'd0;
    chk("t6_async_reset", 0, 0);
    step(); rst_n = 1'b1; idle(); set_dec(1, 11, 0, 0, 0, 0); chk("t6_post_reset", 0, 0);
    step(); idle(); set_dec(0, 0, 0, 0, 1, 12); chk("t6_issue_p12", 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(); idle(); set_dec(1, 12, 0, 0, 0, 0); chk("t6_wrap_stall", 1, 1);
    end
    step(); idle(); set_wb(12); set_dec(1, 12, 0, 0, 0, 0); chk("t6_wrap_zero", 0, 1);
    step(); idle(); chk("end_idle", 0, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
